// File: rtl/crt_vert_timing.sv
// Vertical timing for the CRT controller: line counter, scan-line-in-row counter,
// display enable, split-screen compare and vertical sync, all advanced by the horizontal line tick.
module crt_vert_timing #(
    parameter int VCNT_W = 11
) (
    input  logic              t_crt_clk,
    input  logic              hreset_n,
    input  logic              c_hline_tick,
    input  logic [VCNT_W-1:0] reg_vtotal,
    input  logic [VCNT_W-1:0] reg_vde_end,
    input  logic [VCNT_W-1:0] reg_line_cmp,
    input  logic [VCNT_W-1:0] reg_vrs,
    input  logic [3:0]        reg_vre,
    input  logic [4:0]        reg_max_scan,
    input  logic              c_dbl_scan,
    input  logic              c_vsync_pol,
    output logic [VCNT_W-1:0] c_vcnt,
    output logic [4:0]        c_slc_op,
    output logic              c_vde,
    output logic              c_pre_vde,
    output logic              c_row_end,
    output logic              c_split_screen_pulse,
    output logic              c_crt_line_end,
    output logic              c_vsync
);

    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic [4:0]        slc_q, slc_d;
    logic              phase_q, phase_d;
    logic              vde_q, vde_d;
    logic              pre_vde_q, pre_vde_d;
    logic              vs_active_q, vs_active_d;
    logic              row_end_q;
    logic              split_q;
    logic              tick_dly_q;
    logic              line_end_q;

    logic frame_wrap;
    logic split_hit;
    logic slc_adv;
    logic row_hit;

    // Event precedence on a tick: frame wrap, then split compare, then row end.
    always_comb begin
        frame_wrap = (vcnt_q == reg_vtotal);
        split_hit  = !frame_wrap && (vcnt_q == reg_line_cmp) && (reg_line_cmp < reg_vtotal);
        slc_adv    = c_dbl_scan ? phase_q : 1'b1;
        // ">=" also catches a max-scan value lowered below the current scan line
        row_hit    = !frame_wrap && !split_hit && slc_adv && (slc_q >= reg_max_scan);

        vcnt_d = frame_wrap ? '0 : vcnt_q + VCNT_W'(1);

        slc_d   = slc_q;
        phase_d = c_dbl_scan ? ~phase_q : 1'b1;
        if (frame_wrap || split_hit) begin
            slc_d   = 5'd0;
            phase_d = 1'b0;
        end else if (slc_adv) begin
            slc_d = row_hit ? 5'd0 : slc_q + 5'd1;
        end

        vde_d     = (vcnt_d <= reg_vde_end);
        pre_vde_d = (vcnt_d == reg_vtotal);

        vs_active_d = vs_active_q;
        if (vcnt_d == reg_vrs) begin
            vs_active_d = 1'b1;
        end else if (vs_active_q && (vcnt_d[3:0] == reg_vre)) begin
            vs_active_d = 1'b0;
        end
    end

    always_ff @(posedge t_crt_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            vcnt_q      <= '0;
            slc_q       <= 5'd0;
            phase_q     <= 1'b0;
            vde_q       <= 1'b1;
            pre_vde_q   <= 1'b0;
            vs_active_q <= 1'b0;
            row_end_q   <= 1'b0;
            split_q     <= 1'b0;
            tick_dly_q  <= 1'b0;
            line_end_q  <= 1'b0;
        end else begin
            tick_dly_q <= c_hline_tick;
            // Address reload follows the tick by one cycle, once display enable has settled.
            line_end_q <= tick_dly_q & (vde_q | pre_vde_q);
            row_end_q  <= c_hline_tick & row_hit;
            split_q    <= c_hline_tick & split_hit;
            if (c_hline_tick) begin
                vcnt_q      <= vcnt_d;
                slc_q       <= slc_d;
                phase_q     <= phase_d;
                vde_q       <= vde_d;
                pre_vde_q   <= pre_vde_d;
                vs_active_q <= vs_active_d;
            end
        end
    end

    assign c_vcnt               = vcnt_q;
    assign c_slc_op             = slc_q;
    assign c_vde                = vde_q;
    assign c_pre_vde            = pre_vde_q;
    assign c_row_end            = row_end_q;
    assign c_split_screen_pulse = split_q;
    assign c_crt_line_end       = line_end_q;
    assign c_vsync              = vs_active_q ^ c_vsync_pol;

endmodule

// File: tb/tb_crt_vert_timing.sv
// Self-checking bench for crt_vert_timing: directed scenarios plus randomized
// configurations compared against a line/scan-level reference model.
module tb_crt_vert_timing;

    localparam int W = 11;

    logic         t_crt_clk = 1'b0;
    logic         hreset_n;
    logic         c_hline_tick;
    logic [W-1:0] reg_vtotal, reg_vde_end, reg_line_cmp, reg_vrs;
    logic [3:0]   reg_vre;
    logic [4:0]   reg_max_scan;
    logic         c_dbl_scan, c_vsync_pol;
    logic [W-1:0] c_vcnt;
    logic [4:0]   c_slc_op;
    logic         c_vde, c_pre_vde, c_row_end, c_split_screen_pulse, c_crt_line_end, c_vsync;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_vcnt, m_slc;
    bit m_phase, m_vs, m_row, m_split, m_vde, m_pre;

    always #5 t_crt_clk = ~t_crt_clk;

    crt_vert_timing #(.VCNT_W(W)) dut (
        .t_crt_clk            (t_crt_clk),
        .hreset_n             (hreset_n),
        .c_hline_tick         (c_hline_tick),
        .reg_vtotal           (reg_vtotal),
        .reg_vde_end          (reg_vde_end),
        .reg_line_cmp         (reg_line_cmp),
        .reg_vrs              (reg_vrs),
        .reg_vre              (reg_vre),
        .reg_max_scan         (reg_max_scan),
        .c_dbl_scan           (c_dbl_scan),
        .c_vsync_pol          (c_vsync_pol),
        .c_vcnt               (c_vcnt),
        .c_slc_op             (c_slc_op),
        .c_vde                (c_vde),
        .c_pre_vde            (c_pre_vde),
        .c_row_end            (c_row_end),
        .c_split_screen_pulse (c_split_screen_pulse),
        .c_crt_line_end       (c_crt_line_end),
        .c_vsync              (c_vsync)
    );

    task automatic set_cfg(input int vt, input int ve, input int lc, input int vrs,
                           input int vre, input int ms, input bit dbl, input bit pol);
        reg_vtotal   = W'(vt);
        reg_vde_end  = W'(ve);
        reg_line_cmp = W'(lc);
        reg_vrs      = W'(vrs);
        reg_vre      = 4'(vre);
        reg_max_scan = 5'(ms);
        c_dbl_scan   = dbl;
        c_vsync_pol  = pol;
    endtask

    task automatic model_reset();
        m_vcnt = 0; m_slc = 0; m_phase = 0; m_vs = 0;
        m_row = 0; m_split = 0; m_vde = 1; m_pre = 0;
    endtask

    // One scan line worth of behaviour, stated from the line/row rules.
    task automatic model_tick();
        int  vt, lc;
        bit  wrap, adv;
        vt = int'(reg_vtotal);
        lc = int'(reg_line_cmp);
        wrap    = (m_vcnt == vt);
        m_split = !wrap && (m_vcnt == lc) && (lc < vt);
        adv     = !c_dbl_scan || m_phase;
        m_row   = !wrap && !m_split && adv && (m_slc >= int'(reg_max_scan));
        m_vcnt  = wrap ? 0 : (m_vcnt + 1) % (1 << W);
        if (wrap || m_split) begin
            m_slc = 0;
            m_phase = 0;
        end else begin
            if (adv) m_slc = m_row ? 0 : m_slc + 1;
            m_phase = c_dbl_scan ? !m_phase : 1'b1;
        end
        m_vde = (m_vcnt <= int'(reg_vde_end));
        m_pre = (m_vcnt == vt);
        if (m_vcnt == int'(reg_vrs)) m_vs = 1;
        else if (m_vs && (m_vcnt % 16) == int'(reg_vre)) m_vs = 0;
    endtask

    task automatic do_reset();
        hreset_n = 1'b0;
        c_hline_tick = 1'b0;
        repeat (2) @(negedge t_crt_clk);
        hreset_n = 1'b1;
        @(negedge t_crt_clk);
        model_reset();
    endtask

    // Called at a falling edge; returns at the falling edge right after the tick edge.
    task automatic tick();
        c_hline_tick = 1'b1;
        @(negedge t_crt_clk);
        c_hline_tick = 1'b0;
    endtask

    task automatic test_reset();
        for (int p = 0; p < 2; p++) begin
            set_cfg(9, 7, 1023, 6, 8, 3, 1'b0, p[0]);
            hreset_n = 1'b0;
            c_hline_tick = 1'b1;
            repeat (3) @(negedge t_crt_clk);
            checks++;
            if (c_vcnt !== '0 || c_slc_op !== 5'd0 || c_vde !== 1'b1 || c_pre_vde !== 1'b0 ||
                c_row_end !== 1'b0 || c_split_screen_pulse !== 1'b0 || c_crt_line_end !== 1'b0) begin
                errors++;
                $display("FAIL reset_state pol=%0d: got vcnt=%0d slc=%0d vde=%b pre=%b row=%b split=%b le=%b, exp 0 0 1 0 0 0 0",
                         p, c_vcnt, c_slc_op, c_vde, c_pre_vde, c_row_end, c_split_screen_pulse, c_crt_line_end);
            end
            checks++;
            if (c_vsync !== p[0]) begin
                errors++;
                $display("FAIL reset_vsync pol=%0d: got %b exp %b", p, c_vsync, p[0]);
            end
            $display("reset pol=%0d vcnt=%0d vsync=%b", p, c_vcnt, c_vsync);
        end
        c_hline_tick = 1'b0;
        hreset_n = 1'b1;
        @(negedge t_crt_clk);
    endtask

    task automatic test_basic();
        int v;
        set_cfg(9, 7, 1023, 1000, 0, 3, 1'b0, 1'b0);
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            tick();
            v = i % 10;
            $display("basic tick %0d vcnt=%0d slc=%0d row=%b pre=%b", i, c_vcnt, c_slc_op, c_row_end, c_pre_vde);
            checks++;
            if (c_vcnt !== W'(v)) begin
                errors++; $display("FAIL basic_vcnt tick %0d: got %0d exp %0d", i, c_vcnt, v);
            end
            checks++;
            if (c_pre_vde !== (v == 9) || c_vde !== (v <= 7)) begin
                errors++; $display("FAIL basic_vde tick %0d: got pre=%b vde=%b exp pre=%b vde=%b",
                                   i, c_pre_vde, c_vde, v == 9, v <= 7);
            end
            checks++;
            if (c_row_end !== (v == 4 || v == 8) || c_slc_op !== 5'(v % 4) || c_split_screen_pulse !== 1'b0) begin
                errors++; $display("FAIL basic_row tick %0d: got row=%b slc=%0d split=%b exp row=%b slc=%0d split=0",
                                   i, c_row_end, c_slc_op, c_split_screen_pulse, v == 4 || v == 8, v % 4);
            end
            @(negedge t_crt_clk);
            checks++;
            if (c_crt_line_end !== (v != 8)) begin
                errors++; $display("FAIL basic_line_end tick %0d: got %b exp %b", i, c_crt_line_end, v != 8);
            end
        end
    endtask

    task automatic test_dbl_scan();
        int j;
        set_cfg(9, 7, 1023, 1000, 0, 3, 1'b1, 1'b0);
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            tick();
            j = i % 10;
            $display("dbl tick %0d vcnt=%0d slc=%0d row=%b", i, c_vcnt, c_slc_op, c_row_end);
            checks++;
            if (c_slc_op !== 5'((j / 2) % 4) || c_row_end !== (j == 8)) begin
                errors++; $display("FAIL dbl_scan tick %0d: got slc=%0d row=%b exp slc=%0d row=%b",
                                   i, c_slc_op, c_row_end, (j / 2) % 4, j == 8);
            end
            @(negedge t_crt_clk);
        end
    endtask

    task automatic test_split();
        set_cfg(12, 10, 5, 1000, 0, 3, 1'b0, 1'b0);
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            tick();
            $display("split tick %0d vcnt=%0d slc=%0d split=%b row=%b", i, c_vcnt, c_slc_op, c_split_screen_pulse, c_row_end);
            checks++;
            if (c_split_screen_pulse !== (i == 6)) begin
                errors++; $display("FAIL split_pulse tick %0d: got %b exp %b", i, c_split_screen_pulse, i == 6);
            end
            if (i == 6) begin
                checks++;
                if (c_row_end !== 1'b0 || c_slc_op !== 5'd0 || c_vcnt !== W'(6)) begin
                    errors++; $display("FAIL split_clear: got row=%b slc=%0d vcnt=%0d exp 0 0 6", c_row_end, c_slc_op, c_vcnt);
                end
            end
            if (i > 6) begin
                checks++;
                if (c_row_end !== (i == 10)) begin
                    errors++; $display("FAIL split_next_row tick %0d: got %b exp %b", i, c_row_end, i == 10);
                end
            end
            @(negedge t_crt_clk);
        end
    endtask

    task automatic test_split_at_vtotal();
        set_cfg(9, 7, 9, 1000, 0, 3, 1'b0, 1'b0);
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            tick();
            $display("cmp_eq_vtotal tick %0d vcnt=%0d split=%b", i, c_vcnt, c_split_screen_pulse);
            checks++;
            if (c_split_screen_pulse !== 1'b0 || c_vcnt !== W'(i % 10)) begin
                errors++; $display("FAIL split_eq_vtotal tick %0d: got split=%b vcnt=%0d exp 0 %0d",
                                   i, c_split_screen_pulse, c_vcnt, i % 10);
            end
            @(negedge t_crt_clk);
        end
    endtask

    task automatic test_vsync();
        int  v;
        bit  act;
        set_cfg(12, 10, 1023, 6, 8, 3, 1'b0, 1'b0);
        do_reset();
        for (int i = 1; i <= 26; i++) begin
            if (i == 14) c_vsync_pol = 1'b1;
            tick();
            v = i % 13;
            act = (v == 6 || v == 7);
            $display("vsync tick %0d vcnt=%0d pol=%b vsync=%b", i, c_vcnt, c_vsync_pol, c_vsync);
            checks++;
            if (c_vsync !== (act ^ c_vsync_pol)) begin
                errors++; $display("FAIL vsync tick %0d: got %b exp %b", i, c_vsync, act ^ c_vsync_pol);
            end
            @(negedge t_crt_clk);
        end
    endtask

    task automatic test_mid_reset();
        set_cfg(9, 7, 1023, 1000, 0, 3, 1'b0, 1'b0);
        do_reset();
        repeat (4) begin
            tick();
            @(negedge t_crt_clk);
        end
        #2 hreset_n = 1'b0;
        #1;
        checks++;
        if (c_vcnt !== '0 || c_vde !== 1'b1 || c_pre_vde !== 1'b0 || c_slc_op !== 5'd0) begin
            errors++; $display("FAIL midreset_abort: got vcnt=%0d vde=%b pre=%b slc=%0d exp 0 1 0 0",
                               c_vcnt, c_vde, c_pre_vde, c_slc_op);
        end
        c_hline_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge t_crt_clk);
            checks++;
            if (c_vcnt !== '0 || c_row_end !== 1'b0 || c_crt_line_end !== 1'b0 ||
                c_split_screen_pulse !== 1'b0 || c_vsync !== 1'b0) begin
                errors++; $display("FAIL midreset_hold cyc %0d: got vcnt=%0d row=%b le=%b split=%b vs=%b exp all 0",
                                   i, c_vcnt, c_row_end, c_crt_line_end, c_split_screen_pulse, c_vsync);
            end
        end
        c_hline_tick = 1'b0;
        hreset_n = 1'b1;
        @(negedge t_crt_clk);
        tick();
        $display("midreset first tick vcnt=%0d", c_vcnt);
        checks++;
        if (c_vcnt !== W'(1)) begin
            errors++; $display("FAIL midreset_resume: got vcnt=%0d exp 1", c_vcnt);
        end
        @(negedge t_crt_clk);
        checks++;
        if (c_crt_line_end !== 1'b1) begin
            errors++; $display("FAIL midreset_line_end: got %b exp 1", c_crt_line_end);
        end
    endtask

    task automatic test_random();
        int vt, nt;
        for (int it = 0; it < 6; it++) begin
            vt = $urandom_range(40, 4);
            set_cfg(vt, $urandom_range(vt, 0), $urandom_range(vt + 2, 0), $urandom_range(vt, 0),
                    $urandom_range(15, 0), $urandom_range(7, 0), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)));
            do_reset();
            nt = 2 * vt + 12;
            for (int n = 0; n < nt; n++) begin
                if ($urandom_range(7, 0) == 0) begin
                    reg_max_scan = 5'($urandom_range(7, 0));
                    c_dbl_scan   = 1'($urandom_range(1, 0));
                end
                model_tick();
                tick();
                $display("rand cfg %0d tick %0d vcnt=%0d slc=%0d row=%b split=%b vs=%b",
                         it, n, c_vcnt, c_slc_op, c_row_end, c_split_screen_pulse, c_vsync);
                checks++;
                if (c_vcnt !== W'(m_vcnt) || c_slc_op !== 5'(m_slc)) begin
                    errors++; $display("FAIL rand_count cfg %0d tick %0d: got vcnt=%0d slc=%0d exp %0d %0d",
                                       it, n, c_vcnt, c_slc_op, m_vcnt, m_slc);
                end
                checks++;
                if (c_row_end !== m_row || c_split_screen_pulse !== m_split) begin
                    errors++; $display("FAIL rand_pulse cfg %0d tick %0d: got row=%b split=%b exp %b %b",
                                       it, n, c_row_end, c_split_screen_pulse, m_row, m_split);
                end
                checks++;
                if (c_vde !== m_vde || c_pre_vde !== m_pre || c_vsync !== (m_vs ^ c_vsync_pol)) begin
                    errors++; $display("FAIL rand_enable cfg %0d tick %0d: got vde=%b pre=%b vs=%b exp %b %b %b",
                                       it, n, c_vde, c_pre_vde, c_vsync, m_vde, m_pre, m_vs ^ c_vsync_pol);
                end
                @(negedge t_crt_clk);
                checks++;
                if (c_crt_line_end !== (m_vde | m_pre) || c_row_end !== 1'b0) begin
                    errors++; $display("FAIL rand_line_end cfg %0d tick %0d: got le=%b row=%b exp %b 0",
                                       it, n, c_crt_line_end, c_row_end, m_vde | m_pre);
                end
                repeat ($urandom_range(2, 0)) @(negedge t_crt_clk);
            end
        end
    endtask

    initial begin
        hreset_n = 1'b0;
        c_hline_tick = 1'b0;
        set_cfg(9, 7, 1023, 1000, 0, 3, 1'b0, 1'b0);
        @(negedge t_crt_clk);
        test_reset();
        test_basic();
        test_dbl_scan();
        test_split();
        test_split_at_vtotal();
        test_vsync();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
